div_share_ctrl: RTL
===================

# div_share_ctrl

Sequential controller that shares one repeated-subtraction divider between two requesters. It arbitrates round-robin, latches the winner's operands, and runs one subtract step per clock. It returns quotient, remainder, a requester tag and a one-cycle done pulse. It sits between the lab's operand sources (switch/ALU front ends) and the display/result path, and replaces the unbounded combinational subtract loop with a bounded, clocked sequence.

## Interface
- N, default 4: operand, quotient and remainder width in bits.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req0  in  1  requester 0 wants a division; level; held with operands until gnt0.
- num0  in  N  requester 0 dividend.
- den0  in  N  requester 0 divisor.
- req1  in  1  requester 1 request; same rules as req0.
- num1  in  N  requester 1 dividend.
- den1  in  N  requester 1 divisor.
- gnt0  out  1  one-cycle pulse: requester 0 operands captured.
- gnt1  out  1  one-cycle pulse: requester 1 operands captured.
- busy  out  1  high from the cycle after capture through the done cycle.
- done  out  1  one-cycle pulse: quot, rem, id, div_zero are valid.
- id  out  1  requester that owns the current or last result.
- quot  out  N  quotient.
- rem  out  N  remainder.
- div_zero  out  1  last operation had divisor 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If any reqX is high at the edge, the arbiter picks a winner, latches its numX into rem and its denX into the divisor register, and clears the count.
  - The same edge sets id and gntX, clears div_zero, and moves to RUN.
  - If no request is high, stay in IDLE.
- Arbitration: round-robin on a last-served pointer.
  - Reset value favours requester 0.
  - On a simultaneous request, the requester not served last wins.
  - A lone request always wins.
  - The pointer updates at capture.
- RUN, each edge:
  - Divisor 0: quot = 2^N-1, rem = latched dividend, div_zero = 1; move to DONE.
  - Else if rem >= divisor and count < 2^N-1: rem -= divisor, count += 1; stay in RUN.
  - Else: quot = count; move to DONE.
- DONE: done = 1 for exactly one cycle; next edge returns to IDLE. There is no capture in DONE.
- Arithmetic is unsigned N-bit.
  - The subtract never underflows, because it is guarded by the compare.
  - The count saturates at 2^N-1.
- Results: quot, rem, id and div_zero hold their values after DONE until the next operation reaches DONE.
  - During RUN, rem shows the working value; consumers sample only on done.
- Requests are ignored while not in IDLE.
  - A reqX still high in IDLE after its own done counts as a new request.
- Reset, asynchronous at any time including mid-RUN:
  - State goes to IDLE and the pointer to favour-0.
  - All outputs go to 0: gnt0, gnt1, busy, done, id, quot, rem, div_zero.
  - The in-flight operation is discarded with no done.

## Timing
- Capture edge E0: gntX is high in the cycle after E0; busy rises in the same cycle.
- For quotient q (divisor non-zero):
  - Edges E1..Eq subtract.
  - E(q+1) enters DONE.
  - done is high in the cycle after E(q+1), which is q+1 cycles after the gnt cycle.
- Divisor 0: done is high in the cycle after E1, the same timing as q = 0.
- busy falls with the edge E(q+2) that leaves DONE.
- The next capture can occur at E(q+3) at the earliest.
- Worst case, 15/1 with N = 4: done 16 cycles after gnt; the whole transaction takes 18 edges, capture to IDLE.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Basic: req0 with 13/4 (N = 4), req1 low → gnt0 pulse, then done 4 cycles later with quot = 3, rem = 1, id = 0, div_zero = 0.
- Dividend below divisor: req1 with 2/9 → done 1 cycle after gnt1, quot = 0, rem = 2, id = 1.
- Divide by zero: req0 with 7/0 → done 1 cycle after gnt0, quot = 15, rem = 7, div_zero = 1.
- Fairness: req0 and req1 held high together, all operands 6/2, reqX dropped on its grant and reasserted after done.
  - Required grant order: 0, 1, 0, 1.
  - Every result is quot = 3, rem = 0 with the matching id.
- Worst case and lockout: req0 with 15/1; during RUN raise req1 with 8/2.
  - Expect no gnt1 before done.
  - Expect done 16 cycles after gnt0 with quot = 15, rem = 0.
  - Then gnt1, and quot = 4, rem = 0, id = 1.
- Reset mid-operation: rst_n low 3 cycles after gnt0 of 15/1.
  - All outputs are 0 immediately and no done follows.
  - After release, req1 with 9/3 is granted first-come and returns quot = 3, rem = 0.

Source files
------------

// File: rtl/div_share_ctrl.sv
// Two-requester round-robin front end for one shared repeated-subtraction divider.
// Latency: gnt 1 cycle after capture edge; done q+1 cycles after gnt (1 cycle for divisor 0).
// Backpressure: requests are level-held and ignored until the FSM is back in IDLE.
//
// Ports:
//   clk, rst_n             - clock (rising edge), asynchronous active-low reset
//   req0/num0/den0         - requester 0 level request with dividend/divisor
//   req1/num1/den1         - requester 1 level request with dividend/divisor
//   gnt0/gnt1              - one-cycle pulse when that requester's operands are captured
//   busy                   - high from the cycle after capture through the done cycle
//   done                   - one-cycle pulse, quot/rem/id/div_zero valid
//   id, quot, rem, div_zero- result owner, quotient, remainder, divide-by-zero flag
module div_share_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [N-1:0] num0,
    input  logic [N-1:0] den0,
    input  logic         req1,
    input  logic [N-1:0] num1,
    input  logic [N-1:0] den1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         done,
    output logic         id,
    output logic [N-1:0] quot,
    output logic [N-1:0] rem,
    output logic         div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] MAX_V = {N{1'b1}};
    localparam logic [N-1:0] ONE_V = N'(1);

    state_t       state_q, state_d;
    logic         last_q, last_d;     // requester served most recently
    logic [N-1:0] rem_q, rem_d;       // working remainder, starts as the dividend
    logic [N-1:0] den_q, den_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] quot_q, quot_d;
    logic         id_q, id_d;
    logic         div_zero_q, div_zero_d;
    logic         gnt0_q, gnt0_d;
    logic         gnt1_q, gnt1_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         win;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        rem_d      = rem_q;
        den_d      = den_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        id_d       = id_q;
        div_zero_d = div_zero_q;
        busy_d     = busy_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done_d     = 1'b0;
        // On contention the requester not served last wins; a lone request always wins.
        win        = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d    = S_RUN;
                    last_d     = win;
                    rem_d      = win ? num1 : num0;
                    den_d      = win ? den1 : den0;
                    cnt_d      = '0;
                    id_d       = win;
                    gnt0_d     = ~win;
                    gnt1_d     = win;
                    div_zero_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                if (den_q == '0) begin
                    // rem still holds the untouched dividend here.
                    quot_d     = MAX_V;
                    div_zero_d = 1'b1;
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                end else if ((rem_q >= den_q) && (cnt_q != MAX_V)) begin
                    rem_d = rem_q - den_q;
                    cnt_d = cnt_q + ONE_V;
                end else begin
                    quot_d  = cnt_q;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;           // makes requester 0 win the first contention
            rem_q      <= '0;
            den_q      <= '0;
            cnt_q      <= '0;
            quot_q     <= '0;
            id_q       <= 1'b0;
            div_zero_q <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rem_q      <= rem_d;
            den_q      <= den_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            id_q       <= id_d;
            div_zero_q <= div_zero_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign id       = id_q;
    assign quot     = quot_q;
    assign rem      = rem_q;
    assign div_zero = div_zero_q;

endmodule
